gate_sequencer: RTL and testbench
=================================

# gate_sequencer

Parametrised gate-control sequencer: the next generation of the single-purpose control gate FSM. It accepts command words on a strobe, drives the gate motor with the same one-hot control code, and adds configurable phase durations, a manual open/close mode, obstacle reversal, command handshaking, and status pulses. It sits between the command decoder and the motor driver.

## Interface
- `DATA_W`, 32: command word width.
- `CNT_W`, 16: phase counter width.
- `RAISE_CYCLES`, 5: duration of the go-high phase; must be 1..2^CNT_W-1.
- `HOLD_CYCLES`, 5: open dwell in auto-cycle mode; must be 1..2^CNT_W-1.
- `LOWER_CYCLES`, 5: duration of the go-low phase; must be 1..2^CNT_W-1.

Ports:
- `clk` in 1: the single clock; all logic is on the posedge.
- `rst` in 1: asynchronous, active-high reset.
- `tx` in 1: command strobe; qualified by `ready`.
- `dataIn` in DATA_W: command code, sampled when `tx && ready`.
- `obstacle` in 1: safety sensor, level-sensitive.
- `ready` out 1: the block can accept a command.
- `controlOut` out 3: 001 stop, 010 go high, 100 go low.
- `done` out 1: one-cycle pulse when a close completes.
- `cmd_err` out 1: one-cycle pulse for an illegal or inapplicable command.

## Operation
- Command codes: 1 = CYCLE (auto open, hold, close); 2 = OPEN (open and stay open); 3 = CLOSE. Any other value is illegal.
- States and `controlOut` values:
  - IDLE, 001.
  - RAISE, 010.
  - HOLD, 001: timed open.
  - OPENED, 001: manual open.
  - LOWER, 100.
- `ready` = 1 in IDLE, HOLD and OPENED; it is 0 in RAISE and LOWER. A `tx` while `ready` = 0 is dropped silently, with no `cmd_err`.
- Transitions:
  - IDLE: CYCLE or OPEN moves to RAISE, and the mode is latched.
  - RAISE: after RAISE_CYCLES, moves to HOLD in CYCLE mode or OPENED in OPEN mode.
  - HOLD: after HOLD_CYCLES moves to LOWER; an accepted CLOSE moves to LOWER immediately.
  - OPENED: stays until an accepted CLOSE, then moves to LOWER.
  - LOWER: after LOWER_CYCLES moves to IDLE and pulses `done`.
  - LOWER with `obstacle` = 1 on any cycle: moves to RAISE with the counter cleared and the mode forced to OPEN, so the gate ends in OPENED.
- An accepted command that is illegal, or not applicable to the current state, pulses `cmd_err` and leaves state unchanged. Cases:
  - CLOSE in IDLE.
  - CYCLE or OPEN in HOLD or OPENED.
  - Codes 0 or ≥4 in any state.
- Phase counter: CNT_W bits, cleared on every state entry, increments once per cycle in timed states. A phase of N cycles exits on the edge where count == N-1, so `controlOut` holds its value for exactly N cycles. The counter never wraps.

## Timing
- Reset values: state IDLE, counter 0, mode CYCLE, `controlOut` 001, `ready` 1, `done` 0, `cmd_err` 0.
- `controlOut`, `done` and `cmd_err` are registered from the next-state value. If a command is accepted at edge k, `controlOut` shows 010 from edge k, i.e. 1-cycle latency from the strobe.
- `ready` is decoded combinationally from the registered state.
- `done` is high in the first IDLE cycle after LOWER completes.
- Simultaneous events:
  - `obstacle` on the final LOWER cycle: reversal wins and no `done` pulse is produced.
  - CLOSE on the final HOLD cycle: goes to LOWER once, with no error.
- Reset asserted mid-phase: all outputs take their reset values asynchronously. After release, the first edge behaves as IDLE.

## Structure
- Package `gate_pkg` holds:
  - state enum (IDLE, RAISE, HOLD, OPENED, LOWER);
  - command code constants (CMD_CYCLE = 1, CMD_OPEN = 2, CMD_CLOSE = 3);
  - control encodings (CTL_STOP = 3'b001, CTL_HIGH = 3'b010, CTL_LOW = 3'b100).
- Sub-module `phase_timer`, parametrised by CNT_W:
  - inputs: `clr`, `en`, terminal value;
  - output: `last` (count == term-1).
  - It is instantiated once; the FSM selects the terminal value by state.

## Test plan
- Reset, then CYCLE with defaults: `controlOut` is 010 for 5 cycles, then 001 for 5, then 100 for 5, then 001. `done` pulses once. `ready` is 0 during RAISE and LOWER.
- OPEN: after RAISE, the block stays 001 for 50 cycles with `ready` = 1. Then CLOSE: 100 for 5 cycles, `done`.
- CYCLE, then CLOSE on the 2nd HOLD cycle: LOWER begins on the next cycle and HOLD is truncated.
- CYCLE, then `obstacle` = 1 on the 3rd LOWER cycle: `controlOut` is 010 for 5 cycles, then OPENED, with no `done`. `obstacle` on the last LOWER cycle: same result.
- Illegal and inapplicable commands:
  - `dataIn` = 7 in IDLE: `cmd_err` pulses and the block stays IDLE.
  - CLOSE in IDLE: `cmd_err` pulses.
  - `tx` during RAISE: ignored, with no `cmd_err`.
- `rst` asserted asynchronously mid-RAISE: `controlOut` is 001 immediately. After release, a new CYCLE runs normally; repeat with RAISE_CYCLES = 1 and HOLD_CYCLES = 1.

Source files
------------

// File: rtl/gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | gate_pkg: shared states, command codes and control encodings   |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAISE  = 3'd1,
    HOLD   = 3'd2,
    OPENED = 3'd3,
    LOWER  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_CYCLE = 1'b0,
    MODE_OPEN  = 1'b1
  } mode_t;

  localparam int unsigned CMD_CYCLE = 1;
  localparam int unsigned CMD_OPEN  = 2;
  localparam int unsigned CMD_CLOSE = 3;

  localparam logic [2:0] CTL_STOP = 3'b001;
  localparam logic [2:0] CTL_HIGH = 3'b010;
  localparam logic [2:0] CTL_LOW  = 3'b100;

  function automatic logic [2:0] ctl_of(input state_t s);
    case (s)
      RAISE:   ctl_of = CTL_HIGH;
      LOWER:   ctl_of = CTL_LOW;
      default: ctl_of = CTL_STOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sequencer_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | phase_timer: phase counter flagging the last cycle of a phase  |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             last
);

  logic [CNT_W-1:0] r_count;

  assign last = (r_count == term - CNT_W'(1));

  // Holding at term-1 keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !last) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gate_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | gate_sequencer: command-driven gate motor sequencer            |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module gate_sequencer
  import gate_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int RAISE_CYCLES = 5,
  parameter int HOLD_CYCLES  = 5,
  parameter int LOWER_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              obstacle,
  output logic              ready,
  output logic [2:0]        controlOut,
  output logic              done,
  output logic              cmd_err
);

  localparam logic [CNT_W-1:0] RAISE_T = CNT_W'(RAISE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOWER_T = CNT_W'(LOWER_CYCLES);

  state_t           r_state;
  mode_t            r_mode;
  state_t           w_next;
  mode_t            w_mode_next;
  logic             w_err;
  logic             w_done;
  logic             w_accept;
  logic             w_is_cycle;
  logic             w_is_open;
  logic             w_is_close;
  logic             w_last;
  logic             w_en;
  logic             w_clr;
  logic [CNT_W-1:0] w_term;

  assign ready      = (r_state == IDLE) || (r_state == HOLD) || (r_state == OPENED);
  assign w_accept   = tx && ready;
  assign w_is_cycle = (dataIn == DATA_W'(CMD_CYCLE));
  assign w_is_open  = (dataIn == DATA_W'(CMD_OPEN));
  assign w_is_close = (dataIn == DATA_W'(CMD_CLOSE));

  assign w_en  = (r_state == RAISE) || (r_state == HOLD) || (r_state == LOWER);
  assign w_clr = (w_next != r_state);

  always_comb begin
    case (r_state)
      RAISE:   w_term = RAISE_T;
      HOLD:    w_term = HOLD_T;
      LOWER:   w_term = LOWER_T;
      default: w_term = CNT_W'(1);
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_en),
    .term (w_term),
    .last (w_last)
  );

  always_comb begin
    w_next      = r_state;
    w_mode_next = r_mode;
    w_err       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_cycle) begin
            w_next      = RAISE;
            w_mode_next = MODE_CYCLE;
          end else if (w_is_open) begin
            w_next      = RAISE;
            w_mode_next = MODE_OPEN;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      RAISE: begin
        if (w_last) begin
          w_next = (r_mode == MODE_OPEN) ? OPENED : HOLD;
        end
      end
      HOLD: begin
        // A CLOSE landing on the final hold cycle simply merges with the timeout.
        if (w_accept) begin
          if (w_is_close) begin
            w_next = LOWER;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_last) begin
          w_next = LOWER;
        end
      end
      OPENED: begin
        if (w_accept) begin
          if (w_is_close) begin
            w_next = LOWER;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      LOWER: begin
        // Obstacle reversal outranks completion, so no done on a reversed close.
        if (obstacle) begin
          w_next      = RAISE;
          w_mode_next = MODE_OPEN;
        end else if (w_last) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mode     <= MODE_CYCLE;
      controlOut <= CTL_STOP;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mode     <= w_mode_next;
      controlOut <= ctl_of(w_next);
      done       <= w_done;
      cmd_err    <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_gate_sequencer: directed self-checking bench                |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module tb_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        tx;
  logic [31:0] dataIn;
  logic        obstacle;

  logic        ready, done, cmd_err;
  logic [2:0]  controlOut;
  logic        ready2, done2, cmd_err2;
  logic [2:0]  controlOut2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (tx),
    .dataIn     (dataIn),
    .obstacle   (obstacle),
    .ready      (ready),
    .controlOut (controlOut),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  gate_sequencer #(
    .RAISE_CYCLES (1),
    .HOLD_CYCLES  (1)
  ) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .tx         (tx),
    .dataIn     (dataIn),
    .obstacle   (obstacle),
    .ready      (ready2),
    .controlOut (controlOut2),
    .done       (done2),
    .cmd_err    (cmd_err2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] code);
    tx     = 1'b1;
    dataIn = code;
    tick;
    tx     = 1'b0;
    dataIn = '0;
  endtask

  task automatic phase(input string tag, input logic [2:0] ctl, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_ctl"}, {1'b0, controlOut}, {1'b0, ctl});
      chk({tag, "_ready"}, {3'b0, ready}, {3'b0, rdy});
      chk({tag, "_done"}, {3'b0, done}, 4'd0);
      chk({tag, "_err"}, {3'b0, cmd_err}, 4'd0);
      tick;
    end
  endtask

  task automatic end_close(input string tag);
    chk({tag, "_done"}, {3'b0, done}, 4'd1);
    chk({tag, "_ctl"}, {1'b0, controlOut}, 4'b0001);
    chk({tag, "_ready"}, {3'b0, ready}, 4'd1);
    tick;
    chk({tag, "_done_clr"}, {3'b0, done}, 4'd0);
  endtask

  task automatic run_cycle(input string tag);
    send(32'd1);
    phase({tag, "_raise"}, 3'b010, 1'b0, 5);
    phase({tag, "_hold"}, 3'b001, 1'b1, 5);
    phase({tag, "_lower"}, 3'b100, 1'b0, 5);
    end_close(tag);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; tx = 1'b0; dataIn = '0; obstacle = 1'b0;
    tick;
    tick;
    chk("rst_ctl", {1'b0, controlOut}, 4'b0001);
    chk("rst_ready", {3'b0, ready}, 4'd1);
    chk("rst_done", {3'b0, done}, 4'd0);
    chk("rst_err", {3'b0, cmd_err}, 4'd0);
    rst = 1'b0;
    tick;
    chk("idle_ctl", {1'b0, controlOut}, 4'b0001);

    run_cycle("cycle");

    // Manual open, long dwell, then close
    send(32'd2);
    phase("open_raise", 3'b010, 1'b0, 5);
    phase("opened", 3'b001, 1'b1, 50);
    send(32'd3);
    phase("open_lower", 3'b100, 1'b0, 5);
    end_close("open");

    // CLOSE on the 2nd HOLD cycle truncates the hold
    send(32'd1);
    phase("tr_raise", 3'b010, 1'b0, 5);
    phase("tr_hold", 3'b001, 1'b1, 1);
    send(32'd3);
    phase("tr_lower", 3'b100, 1'b0, 5);
    end_close("tr");

    // CLOSE on the final HOLD cycle: single lower, no error
    send(32'd1);
    phase("fh_raise", 3'b010, 1'b0, 5);
    phase("fh_hold", 3'b001, 1'b1, 4);
    send(32'd3);
    phase("fh_lower", 3'b100, 1'b0, 5);
    end_close("fh");

    // Obstacle on 3rd LOWER cycle
    send(32'd1);
    phase("ob3_raise", 3'b010, 1'b0, 5);
    phase("ob3_hold", 3'b001, 1'b1, 5);
    phase("ob3_lower", 3'b100, 1'b0, 2);
    chk("ob3_lower3_ctl", {1'b0, controlOut}, 4'b0100);
    obstacle = 1'b1;
    tick;
    obstacle = 1'b0;
    phase("ob3_rev", 3'b010, 1'b0, 5);
    phase("ob3_opened", 3'b001, 1'b1, 3);
    send(32'd3);
    phase("ob3_close", 3'b100, 1'b0, 5);
    end_close("ob3");

    // Obstacle on the final LOWER cycle: reversal, no done
    send(32'd1);
    phase("obl_raise", 3'b010, 1'b0, 5);
    phase("obl_hold", 3'b001, 1'b1, 5);
    phase("obl_lower", 3'b100, 1'b0, 4);
    obstacle = 1'b1;
    tick;
    obstacle = 1'b0;
    phase("obl_rev", 3'b010, 1'b0, 5);
    phase("obl_opened", 3'b001, 1'b1, 3);
    send(32'd3);
    phase("obl_close", 3'b100, 1'b0, 5);
    end_close("obl");

    // Illegal and inapplicable commands in IDLE
    send(32'd7);
    chk("ill7_err", {3'b0, cmd_err}, 4'd1);
    chk("ill7_ctl", {1'b0, controlOut}, 4'b0001);
    chk("ill7_ready", {3'b0, ready}, 4'd1);
    tick;
    chk("ill7_err_clr", {3'b0, cmd_err}, 4'd0);
    send(32'd3);
    chk("idle_close_err", {3'b0, cmd_err}, 4'd1);
    chk("idle_close_ctl", {1'b0, controlOut}, 4'b0001);
    send(32'd0);
    chk("ill0_err", {3'b0, cmd_err}, 4'd1);
    tick;

    // tx during RAISE dropped; OPEN during HOLD flagged
    send(32'd1);
    chk("drop_ctl", {1'b0, controlOut}, 4'b0010);
    send(32'd3);
    phase("drop_raise", 3'b010, 1'b0, 4);
    send(32'd2);
    chk("hold_open_err", {3'b0, cmd_err}, 4'd1);
    chk("hold_open_ctl", {1'b0, controlOut}, 4'b0001);
    tick;
    phase("drop_hold", 3'b001, 1'b1, 3);
    phase("drop_lower", 3'b100, 1'b0, 5);
    end_close("drop");

    // Asynchronous reset mid-RAISE
    send(32'd1);
    tick;
    chk("ar_pre_ctl", {1'b0, controlOut}, 4'b0010);
    rst = 1'b1;
    #1;
    chk("ar_ctl", {1'b0, controlOut}, 4'b0001);
    chk("ar_ready", {3'b0, ready}, 4'd1);
    tick;
    rst = 1'b0;
    run_cycle("after_rst");

    // Short-phase instance: RAISE_CYCLES = HOLD_CYCLES = 1
    rst  = 1'b1;
    rst2 = 1'b0;
    tick;
    send(32'd1);
    chk("s_raise_ctl", {1'b0, controlOut2}, 4'b0010);
    chk("s_raise_ready", {3'b0, ready2}, 4'd0);
    rst2 = 1'b1;
    #1;
    chk("s_ar_ctl", {1'b0, controlOut2}, 4'b0001);
    tick;
    rst2 = 1'b0;
    send(32'd1);
    chk("s2_raise_ctl", {1'b0, controlOut2}, 4'b0010);
    tick;
    chk("s2_hold_ctl", {1'b0, controlOut2}, 4'b0001);
    chk("s2_hold_ready", {3'b0, ready2}, 4'd1);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("s2_lower_ctl", {1'b0, controlOut2}, 4'b0100);
      chk("s2_lower_done", {3'b0, done2}, 4'd0);
      tick;
    end
    chk("s2_done", {3'b0, done2}, 4'd1);
    chk("s2_idle_ctl", {1'b0, controlOut2}, 4'b0001);
    chk("s2_err", {3'b0, cmd_err2}, 4'd0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
